xpb_accum_serial: RTL and testbench



---
 rtl/xpb_accum_serial_pkg.sv | 15 +
 rtl/xpb_accum_serial_if.sv | 27 ++
 rtl/xpb_accum_serial_limb_add.sv | 36 +++
 rtl/xpb_accum_serial.sv | 142 ++++++++++++++
 tb/tb_xpb_accum_serial.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/xpb_accum_serial_pkg.sv
// Shared types and defaults for the XPB carry-save accumulator.
package xpb_acc_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_e;

  localparam int DEF_DATA_W  = 1024;
  localparam int DEF_GUARD_W = 6;
  localparam int DEF_LIMB_W  = 64;

  // Number of limb-serial resolve cycles needed to cover out_w bits.
  function automatic int calc_limbs(input int out_w, input int limb_w);
    return (out_w + limb_w - 1) / limb_w;
  endfunction

endpackage

// File: rtl/xpb_accum_serial_if.sv
// Term-input / result-output bundle of the XPB accumulator.
interface xpb_accum_serial_if
  import xpb_acc_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int GUARD_W = DEF_GUARD_W
) ();
  logic                      in_valid;
  logic                      in_last;
  logic                      in_ready;
  logic [DATA_W-1:0]         xpb_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W+GUARD_W-1:0] sum_out;
  logic [GUARD_W:0]          term_cnt;
  logic                      ovf;

  modport master (
    output in_valid, in_last, xpb_in, out_ready,
    input  in_ready, out_valid, sum_out, term_cnt, ovf
  );

  modport slave (
    input  in_valid, in_last, xpb_in, out_ready,
    output in_ready, out_valid, sum_out, term_cnt, ovf
  );
endinterface

// File: rtl/xpb_accum_serial_limb_add.sv
// Limb adder with a registered carry between consecutive limbs.
// TOP_W bits are kept on the top limb and its carry-out is dropped.
module xpb_acc_limb_add #(
  parameter int LIMB_W = 64,
  parameter int TOP_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic              is_top,
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  output logic [LIMB_W-1:0] sum
);
  localparam logic [LIMB_W-1:0] TOP_MASK = {LIMB_W{1'b1}} >> (LIMB_W - TOP_W);

  logic          carry_q, carry_d;
  logic [LIMB_W:0] full;

  // Limb sum and next carry; clr seeds a fresh resolve with carry 0.
  always_comb begin
    full    = {1'b0, a} + {1'b0, b} + (LIMB_W + 1)'(carry_q);
    sum     = full[LIMB_W-1:0];
    carry_d = carry_q;
    if (is_top) sum = full[LIMB_W-1:0] & TOP_MASK;
    if (clr) carry_d = 1'b0;
    else if (en) carry_d = is_top ? 1'b0 : full[LIMB_W];
  end

  // Carry register.
  always_ff @(posedge clk) begin
    if (reset) carry_q <= 1'b0;
    else       carry_q <= carry_d;
  end
endmodule

// File: rtl/xpb_accum_serial.sv
// Carry-save accumulator of xpb terms with limb-serial final resolve.
// Optional macro XPB_ACC_OVF_CHECK_EN: saturating term count + sticky ovf.
module xpb_accum_serial
  import xpb_acc_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int GUARD_W = DEF_GUARD_W,
  parameter int LIMB_W  = DEF_LIMB_W
) (
  input logic               clk,
  input logic               reset,
  xpb_accum_serial_if.slave bus
);
  localparam int OUT_W = DATA_W + GUARD_W;
  localparam int LIMBS = calc_limbs(OUT_W, LIMB_W);
  localparam int IDX_W = $clog2(LIMBS);
  localparam int TOP_W = OUT_W - (LIMBS - 1) * LIMB_W;
  localparam int CNT_W = GUARD_W + 1;
  localparam logic [IDX_W-1:0] LAST_LIMB = IDX_W'(LIMBS - 1);

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   s_q, s_d, c_q, c_d, sum_q, sum_d;
  logic [IDX_W-1:0]   limb_q, limb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               in_ready, out_valid, accept, start_resolve;
  logic [OUT_W-1:0]   x_ext, maj;
  logic [31:0]        shamt;
  logic [LIMB_W-1:0]  limb_a, limb_b, limb_sum;

  assign accept        = bus.in_valid && in_ready;
  assign start_resolve = accept && bus.in_last;
  assign x_ext         = OUT_W'(bus.xpb_in);
  assign shamt         = 32'(limb_q) * LIMB_W;
  assign limb_a        = LIMB_W'(s_q >> shamt);
  assign limb_b        = LIMB_W'(c_q >> shamt);

  xpb_acc_limb_add #(.LIMB_W(LIMB_W), .TOP_W(TOP_W)) u_limb_add (
    .clk    (clk),
    .reset  (reset),
    .clr    (start_resolve),
    .en     (state_q == RESOLVE),
    .is_top (limb_q == LAST_LIMB),
    .a      (limb_a),
    .b      (limb_b),
    .sum    (limb_sum)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: if (accept) state_d = bus.in_last ? RESOLVE : ACCUM;
      RESOLVE:     if (limb_q == LAST_LIMB) state_d = DONE;
      DONE:        if (bus.out_ready) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    out_valid = (state_q == DONE);
  end

`ifdef XPB_ACC_OVF_CHECK_EN
  logic ovf_q, ovf_d;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Sticky overflow: a term arrives once the guard range is already full.
  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      if (state_q == IDLE) ovf_d = 1'b0;
      else if (cnt_q == (CNT_W'(1) << GUARD_W)) ovf_d = 1'b1;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end
  assign bus.ovf = ovf_q;
`else
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign bus.ovf = 1'b0;
`endif

  // Carry-save accumulate, term count and limb-serial resolve.
  always_comb begin
    s_d    = s_q;
    c_d    = c_q;
    sum_d  = sum_q;
    limb_d = limb_q;
    cnt_d  = cnt_q;
    maj    = (s_q & c_q) | (s_q & x_ext) | (c_q & x_ext);
    if (accept) begin
      if (state_q == IDLE) begin
        s_d   = x_ext;
        c_d   = '0;
        cnt_d = CNT_W'(1);
        sum_d = '0;
      end else begin
        s_d   = s_q ^ c_q ^ x_ext;
        c_d   = maj << 1;
        cnt_d = cnt_inc;
      end
    end
    if (state_q == RESOLVE) begin
      sum_d  = (sum_q & ~(OUT_W'({LIMB_W{1'b1}}) << shamt)) | (OUT_W'(limb_sum) << shamt);
      limb_d = (limb_q == LAST_LIMB) ? '0 : limb_q + IDX_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q    <= '0;
      c_q    <= '0;
      sum_q  <= '0;
      limb_q <= '0;
      cnt_q  <= '0;
    end else begin
      s_q    <= s_d;
      c_q    <= c_d;
      sum_q  <= sum_d;
      limb_q <= limb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.sum_out   = sum_q;
  assign bus.term_cnt  = cnt_q;
endmodule

// File: tb/tb_xpb_accum_serial.sv
// Self-checking bench for xpb_accum_serial; reference sum is a plain
// modular addition of every accepted term.
module tb_xpb_accum_serial;
  import xpb_acc_pkg::*;

  localparam int DATA_W  = 1024;
  localparam int GUARD_W = 6;
  localparam int OUT_W   = DATA_W + GUARD_W;
  localparam int CNT_W   = GUARD_W + 1;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [OUT_W-1:0] exp_sum;
  int               exp_terms;

  xpb_accum_serial_if #(.DATA_W(DATA_W), .GUARD_W(GUARD_W)) bus ();

  xpb_accum_serial #(.DATA_W(DATA_W), .GUARD_W(GUARD_W), .LIMB_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic int exp_cnt(input int n);
`ifdef XPB_ACC_OVF_CHECK_EN
    return (n > 127) ? 127 : n;
`else
    return n % 128;
`endif
  endfunction

  function automatic bit exp_ovf(input int n);
`ifdef XPB_ACC_OVF_CHECK_EN
    return n > 64;
`else
    return (n < 0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed n terms (all-ones or random) with random idle gaps; last has in_last.
  task automatic send_terms(input int n, input bit ones, input int max_gap);
    logic [DATA_W-1:0] x;
    int gap;
    exp_sum   = '0;
    exp_terms = 0;
    for (int i = 0; i < n; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        bus.in_valid = 1'b0;
        bus.xpb_in   = rand_word();
        bus.in_last  = 1'($urandom_range(1, 0));
        tick();
      end
      x = ones ? {DATA_W{1'b1}} : rand_word();
      bus.in_valid = 1'b1;
      bus.xpb_in   = x;
      bus.in_last  = (i == n - 1);
      tick();
      exp_sum   = exp_sum + {{GUARD_W{1'b0}}, x};
      exp_terms = exp_terms + 1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Count edges from the in_last accept until out_valid; flag in_ready seen high.
  task automatic wait_done(output int lat, output bit rdy_bad);
    lat     = 0;
    rdy_bad = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) rdy_bad = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.sum_out !== '0) begin errors++; $display("FAIL reset_sum got %h exp 0 (low128)", bus.sum_out[127:0]); end
    checks++; if (bus.term_cnt !== '0) begin errors++; $display("FAIL reset_term_cnt got %0d exp 0", bus.term_cnt); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.ovf); end
    $display("txn reset done");
  endtask

  task automatic test_single();
    int lat; bit rdy_bad;
    bus.in_valid = 1'b1; bus.xpb_in = DATA_W'(1); bus.in_last = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    wait_done(lat, rdy_bad);
    checks++; if (lat !== 17) begin errors++; $display("FAIL single_latency got %0d exp 17", lat); end
    checks++; if (rdy_bad) begin errors++; $display("FAIL single_in_ready_resolve got 1 exp 0"); end
    checks++; if (bus.sum_out !== OUT_W'(1)) begin errors++; $display("FAIL single_sum got %h exp 1 (low128)", bus.sum_out[127:0]); end
    checks++; if (bus.term_cnt !== CNT_W'(1)) begin errors++; $display("FAIL single_term_cnt got %0d exp 1", bus.term_cnt); end
    $display("txn single term=1 latency=%0d sum_low=%h", lat, bus.sum_out[63:0]);
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat; bit rdy_bad;
    logic [OUT_W-1:0] ref_const;
    ref_const = '0;
    ref_const[DATA_W+1] = 1'b1;
    ref_const = ref_const - OUT_W'(2);
    send_terms(2, 1'b1, 0);
    wait_done(lat, rdy_bad);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid got %b exp 1 after %0d edges", bus.out_valid, lat); end
    checks++; if (bus.sum_out !== ref_const || exp_sum !== ref_const) begin errors++; $display("FAIL b2b_sum got %h exp %h (top128)", bus.sum_out[OUT_W-1 -: 128], ref_const[OUT_W-1 -: 128]); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b exp 0", bus.ovf); end
    checks++; if (bus.term_cnt !== CNT_W'(2)) begin errors++; $display("FAIL b2b_term_cnt got %0d exp 2", bus.term_cnt); end
    $display("txn back_to_back terms=2 latency=%0d", lat);
    handshake();
  endtask

  task automatic test_random();
    int lat; bit rdy_bad; int n;
    for (int r = 0; r < 5; r++) begin
      n = int'($urandom_range(12, 1));
      send_terms(n, 1'b0, 3);
      wait_done(lat, rdy_bad);
      checks++; if (lat !== 17 || rdy_bad) begin errors++; $display("FAIL rand_latency got %0d rdy_bad %b exp 17 0", lat, rdy_bad); end
      checks++; if (bus.sum_out !== exp_sum) begin errors++; $display("FAIL rand_sum got %h exp %h (low128)", bus.sum_out[127:0], exp_sum[127:0]); end
      checks++; if (bus.term_cnt !== CNT_W'(exp_cnt(n))) begin errors++; $display("FAIL rand_term_cnt got %0d exp %0d", bus.term_cnt, exp_cnt(n)); end
      $display("txn random terms=%0d sum_low=%h", n, bus.sum_out[63:0]);
      handshake();
    end
  endtask

  task automatic test_full64();
    int lat; bit rdy_bad;
    logic [OUT_W-1:0] ref_const;
    ref_const = '0;
    ref_const = ref_const - OUT_W'(64);
    send_terms(64, 1'b1, 2);
    wait_done(lat, rdy_bad);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL full64_out_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.sum_out !== ref_const || exp_sum !== ref_const) begin errors++; $display("FAIL full64_sum got %h exp %h (low128)", bus.sum_out[127:0], ref_const[127:0]); end
    checks++; if (bus.term_cnt !== CNT_W'(64)) begin errors++; $display("FAIL full64_term_cnt got %0d exp 64", bus.term_cnt); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL full64_ovf got %b exp 0", bus.ovf); end
    $display("txn full64 terms=64 latency=%0d", lat);
    handshake();
  endtask

  task automatic test_ovf();
    int lat; bit rdy_bad;
    send_terms(65, 1'b0, 1);
    checks++; if (bus.ovf !== exp_ovf(65)) begin errors++; $display("FAIL ovf_flag got %b exp %b", bus.ovf, exp_ovf(65)); end
    wait_done(lat, rdy_bad);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_out_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.term_cnt !== CNT_W'(exp_cnt(65))) begin errors++; $display("FAIL ovf_term_cnt got %0d exp %0d", bus.term_cnt, exp_cnt(65)); end
    checks++; if (bus.ovf !== exp_ovf(65)) begin errors++; $display("FAIL ovf_sticky got %b exp %b", bus.ovf, exp_ovf(65)); end
    $display("txn ovf terms=65 ovf=%b term_cnt=%0d", bus.ovf, bus.term_cnt);
    handshake();
  endtask

  task automatic test_backpressure();
    int lat; bit rdy_bad; bit unstable;
    logic [OUT_W-1:0] held_sum;
    logic [CNT_W-1:0] held_cnt;
    send_terms(2, 1'b0, 0);
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_cleared got %b exp 0", bus.ovf); end
    wait_done(lat, rdy_bad);
    checks++; if (bus.sum_out !== exp_sum) begin errors++; $display("FAIL bp_sum got %h exp %h (low128)", bus.sum_out[127:0], exp_sum[127:0]); end
    held_sum = bus.sum_out;
    held_cnt = bus.term_cnt;
    unstable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.xpb_in    = rand_word();
      bus.in_last   = 1'b1;
      tick();
      if (bus.sum_out !== held_sum || bus.term_cnt !== held_cnt || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) unstable = 1'b1;
    end
    checks++; if (unstable) begin errors++; $display("FAIL bp_stable got changed exp held (cnt %0d vld %b rdy %b)", bus.term_cnt, bus.out_valid, bus.in_ready); end
    bus.out_ready = 1'b1;
    bus.xpb_in    = DATA_W'(7);
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_to_idle got vld %b rdy %b exp 0 1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.term_cnt !== CNT_W'(2)) begin errors++; $display("FAIL bp_no_same_edge_accept got %0d exp 2", bus.term_cnt); end
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    checks++; if (bus.term_cnt !== CNT_W'(1)) begin errors++; $display("FAIL bp_next_accept got %0d exp 1", bus.term_cnt); end
    wait_done(lat, rdy_bad);
    checks++; if (bus.sum_out !== OUT_W'(7) || lat !== 17) begin errors++; $display("FAIL bp_new_sum got %h lat %0d exp 7 lat 17", bus.sum_out[127:0], lat); end
    $display("txn backpressure held=5 new_sum=%h", bus.sum_out[63:0]);
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat; bit rdy_bad;
    bus.in_valid = 1'b1; bus.xpb_in = rand_word(); bus.in_last = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_state got vld %b rdy %b exp 0 1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.sum_out !== '0 || bus.term_cnt !== '0) begin errors++; $display("FAIL rmid_cleared got %h cnt %0d exp 0 0", bus.sum_out[127:0], bus.term_cnt); end
    bus.in_valid = 1'b1; bus.xpb_in = DATA_W'(5); bus.in_last = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    wait_done(lat, rdy_bad);
    checks++; if (lat !== 17 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL rmid_latency got %0d exp 17", lat); end
    checks++; if (bus.sum_out !== OUT_W'(5)) begin errors++; $display("FAIL rmid_sum got %h exp 5 (low128)", bus.sum_out[127:0]); end
    $display("txn reset_mid_resolve new_sum=%h", bus.sum_out[63:0]);
    handshake();
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.xpb_in    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_full64();
    test_ovf();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
